// File: rtl/rf_query_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rf_query_arbiter_pkg: shared widths, tag encoding and buffer state type
// Revision: 1.0
// ============================================================================
package rf_query_arbiter_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int DEF_ROB_WIDTH = 3;
  localparam int DEF_REG_IDX_W = 5;
  localparam int DEF_TAG_W     = DEF_ROB_WIDTH + 1;
  // Tag MSB set means the operand value is already available.
  localparam logic [DEF_TAG_W-1:0] DEF_NON_DEP = DEF_TAG_W'(1) << DEF_ROB_WIDTH;

  // Response layout at default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] qj;
    logic [DEF_TAG_W-1:0] qk;
    logic [RF_DATA_W-1:0] vj;
    logic [RF_DATA_W-1:0] vk;
  } rf_resp_def_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_query_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter: combinational round-robin one-hot grant, search from ptr+1
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(ptr_i) + k) % N;
      if (!w_found && req_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_query_arbiter.sv
`default_nettype none
// ============================================================================
// rf_query_arbiter: round-robin sharing of the RF query/occupy port with
// per-requester one-entry response buffers.  Revision: 1.0
// ============================================================================
module rf_query_arbiter
  import rf_query_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int RoB_WIDTH = 3,
  parameter int REG_IDX_W = 5
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             flush_signal,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*REG_IDX_W-1:0]       req_rs1,
  input  logic [N_REQ*REG_IDX_W-1:0]       req_rs2,
  input  logic [N_REQ*REG_IDX_W-1:0]       req_rd,
  input  logic [N_REQ*RoB_WIDTH-1:0]       req_rob_idx,
  output logic [N_REQ-1:0]                 resp_valid,
  input  logic [N_REQ-1:0]                 resp_ready,
  output logic [N_REQ*(RoB_WIDTH+1)-1:0]   resp_Qj,
  output logic [N_REQ*(RoB_WIDTH+1)-1:0]   resp_Qk,
  output logic [N_REQ*RF_DATA_W-1:0]       resp_Vj,
  output logic [N_REQ*RF_DATA_W-1:0]       resp_Vk,
  output logic [REG_IDX_W-1:0]             rf_rs1,
  output logic [REG_IDX_W-1:0]             rf_rs2,
  input  logic [RoB_WIDTH:0]               rf_Qj,
  input  logic [RoB_WIDTH:0]               rf_Qk,
  input  logic [RF_DATA_W-1:0]             rf_Vj,
  input  logic [RF_DATA_W-1:0]             rf_Vk,
  output logic                             rf_new_entry_en,
  output logic [RoB_WIDTH-1:0]             rf_new_entry_robEntry,
  output logic [REG_IDX_W-1:0]             rf_occupied_rd
);

  localparam int                TAG_W   = RoB_WIDTH + 1;
  localparam int                PTR_W   = ptr_width(N_REQ);
  localparam logic [TAG_W-1:0]  NON_DEP = TAG_W'(1) << RoB_WIDTH;
  localparam logic [PTR_W-1:0]  PTR_RST = PTR_W'(N_REQ - 1);

  typedef struct packed {
    logic [TAG_W-1:0]     qj;
    logic [TAG_W-1:0]     qk;
    logic [RF_DATA_W-1:0] vj;
    logic [RF_DATA_W-1:0] vk;
  } resp_t;

  buf_state_e        state_q [N_REQ];
  buf_state_e        state_d [N_REQ];
  resp_t             resp_q  [N_REQ];
  resp_t             resp_d  [N_REQ];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0]     eligible, arb_req, grant;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;
  logic [REG_IDX_W-1:0] rs1_sel, rs2_sel, rd_sel;
  logic [RoB_WIDTH-1:0] rob_sel;

  for (genvar i = 0; i < N_REQ; i++) begin : g_out
    assign resp_valid[i]                  = (state_q[i] == BUF_FULL);
    assign eligible[i]                    = req_valid[i] && (!resp_valid[i] || resp_ready[i]);
    assign resp_Qj[i*TAG_W +: TAG_W]      = resp_q[i].qj;
    assign resp_Qk[i*TAG_W +: TAG_W]      = resp_q[i].qk;
    assign resp_Vj[i*RF_DATA_W +: RF_DATA_W] = resp_q[i].vj;
    assign resp_Vk[i*RF_DATA_W +: RF_DATA_W] = resp_q[i].vk;
  end

  assign arb_req = (rdy_in && !flush_signal) ? eligible : '0;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  // Grant is one-hot, so OR-ing the masked slices acts as the mux.
  always_comb begin
    rs1_sel   = '0;
    rs2_sel   = '0;
    rd_sel    = '0;
    rob_sel   = '0;
    grant_idx = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        rs1_sel   = rs1_sel | req_rs1[i*REG_IDX_W +: REG_IDX_W];
        rs2_sel   = rs2_sel | req_rs2[i*REG_IDX_W +: REG_IDX_W];
        rd_sel    = rd_sel  | req_rd[i*REG_IDX_W +: REG_IDX_W];
        rob_sel   = rob_sel | req_rob_idx[i*RoB_WIDTH +: RoB_WIDTH];
        grant_idx = PTR_W'(i);
      end
    end
  end

  assign rf_rs1                = rs1_sel;
  assign rf_rs2                = rs2_sel;
  assign rf_occupied_rd        = rd_sel;
  assign rf_new_entry_robEntry = rob_sel;
  assign rf_new_entry_en       = grant_any && (rd_sel != '0);

  always_comb begin
    rr_ptr_d = grant_any ? grant_idx : rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i] = state_q[i];
      resp_d[i]  = resp_q[i];
      if (grant[i]) begin
        resp_d[i] = '{qj: rf_Qj, qk: rf_Qk, vj: rf_Vj, vk: rf_Vk};
      end
      if (rdy_in) begin
        if (flush_signal) begin
          state_d[i] = BUF_EMPTY;
        end else begin
          case (state_q[i])
            BUF_EMPTY: if (grant[i]) state_d[i] = BUF_FULL;
            BUF_FULL:  if (!grant[i] && resp_ready[i]) state_d[i] = BUF_EMPTY;
            default:   state_d[i] = BUF_EMPTY;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_q <= PTR_RST;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= BUF_EMPTY;
        resp_q[i]  <= '{qj: NON_DEP, qk: NON_DEP, vj: '0, vk: '0};
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= state_d[i];
        resp_q[i]  <= resp_d[i];
      end
    end
  end

endmodule
`default_nettype wire
